// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode, funct, ALU code and control state definitions
package mips_pkg;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;
  typedef enum logic [1:0] {
    AOP_ADD = 2'b00,
    AOP_SUB = 2'b01,
    AOP_FUNCT = 2'b10
  } aluop_t;
  typedef enum logic [3:0] {
    FETCH = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD = 4'd3,
    MEMWB = 4'd4,
    MEMWR = 4'd5,
    RTYPEEX = 4'd6,
    ALUWB = 4'd7,
    BEQEX = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JEX = 4'd11
  } ctrl_state_t;
endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// alu_decoder: maps aluop and funct to the ALU operation code
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_control
);
  always_comb
    alu_control = aluop == AOP_ADD ? ALU_ADD :
                  aluop == AOP_SUB ? ALU_SUB :
                  funct == F_ADD ? ALU_ADD :
                  funct == F_SUB ? ALU_SUB :
                  funct == F_AND ? ALU_AND :
                  funct == F_OR ? ALU_OR :
                  funct == F_SLT ? ALU_SLT : ALU_ADD;
endmodule

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore FSM sequencing the multicycle tinymips datapath
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic        pcen,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regdst,
  output logic        mem2reg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  pcsrc,
  output logic [2:0]  alu_control,
  output logic        illegal_op,
  output logic        instr_done
);
  ctrl_state_t r_state, w_next, w_dec;
  aluop_t w_aluop;
  logic w_pcwrite, w_branch, w_memwrite, w_irwrite, w_regwrite, w_illegal, w_done;
  always_ff @(posedge CLK)
    if (RST) r_state <= FETCH;
    else r_state <= w_next;
  always_comb begin
    w_dec = RST ? FETCH : r_state;
    w_next = FETCH;
    w_aluop = AOP_ADD;
    w_pcwrite = 1'b0;
    w_branch = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite = 1'b0;
    w_regwrite = 1'b0;
    w_illegal = 1'b0;
    w_done = 1'b0;
    iord = 1'b0;
    regdst = 1'b0;
    mem2reg = 1'b0;
    alusrca = 1'b0;
    alusrcb = 2'b00;
    pcsrc = 2'b00;
    case (w_dec)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        alusrcb = 2'b01;
        w_next = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        w_next = (op == OP_LW || op == OP_SW) ? MEMADR :
                 op == OP_RTYPE ? RTYPEEX :
                 op == OP_BEQ ? BEQEX :
                 op == OP_ADDI ? ADDIEX :
                 op == OP_J ? JEX : FETCH;
        w_illegal = w_next == FETCH;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next = op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord = 1'b1;
        w_next = MEMWB;
      end
      MEMWB: begin
        mem2reg = 1'b1;
        w_regwrite = 1'b1;
        w_done = 1'b1;
      end
      MEMWR: begin
        iord = 1'b1;
        w_memwrite = 1'b1;
        w_done = 1'b1;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        w_aluop = AOP_FUNCT;
        w_next = ALUWB;
      end
      ALUWB: begin
        regdst = 1'b1;
        w_regwrite = 1'b1;
        w_done = 1'b1;
      end
      BEQEX: begin
        alusrca = 1'b1;
        w_aluop = AOP_SUB;
        pcsrc = 2'b01;
        w_branch = 1'b1;
        w_done = 1'b1;
      end
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        w_next = ADDIWB;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
        w_done = 1'b1;
      end
      JEX: begin
        pcsrc = 2'b10;
        w_pcwrite = 1'b1;
        w_done = 1'b1;
      end
      default: w_next = FETCH;
    endcase
  end
  assign pcen = ~RST & (w_pcwrite | (w_branch & zero));
  assign memwrite = ~RST & w_memwrite;
  assign irwrite = ~RST & w_irwrite;
  assign regwrite = ~RST & w_regwrite;
  assign illegal_op = ~RST & w_illegal;
  assign instr_done = ~RST & w_done;
  alu_decoder u_alu_decoder (
    .aluop(w_aluop),
    .funct(funct),
    .alu_control(alu_control)
  );
endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multicycle main controller for the tinymips core. It decodes the opcode and funct fields of the instruction word, including the lw/sw encodings (`lw` 0x8C00_0000 base, `sw` 0xAC00_0000 base). It then sequences the datapath enables over 3–5 cycles per instruction. It replaces single-cycle control in the multicycle datapath variant, which shares one memory for instructions and data and holds an instruction register.

## Interface
Parameters:
- none; opcode, funct and state encodings are fixed constants in the shared package.

Ports:
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `op`  in  6  instr[31:26], driven from the instruction register.
- `funct`  in  6  instr[5:0], driven from the instruction register.
- `zero`  in  1  ALU zero flag.
- `pcen`  out  1  PC write enable: `pcwrite | (branch & zero)`.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `memwrite`  out  1  memory write enable.
- `irwrite`  out  1  instruction register write enable.
- `regdst`  out  1  destination register select: 0 = rt, 1 = rd.
- `mem2reg`  out  1  writeback source select: 0 = ALUOut, 1 = data register.
- `regwrite`  out  1  register file write enable.
- `alusrca`  out  1  ALU A select: 0 = PC, 1 = register A.
- `alusrcb`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pcsrc`  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_control`  out  3  ALU operation code.
- `illegal_op`  out  1  1-cycle pulse in DECODE when the opcode is unsupported.
- `instr_done`  out  1  1-cycle pulse in the last state of each instruction.

## Operation
- Moore FSM. All outputs are decoded combinationally from the state register, except `pcen` (uses `zero`) and `alu_control` (uses `funct`).
- Listed signals are 1 in that state; unlisted enables and selects are 0.
- FETCH: `irwrite`, `pcwrite`, `alusrcb`=01, aluop=00. Next state is DECODE.
- DECODE: `alusrcb`=11, aluop=00. Next state by `op`:
  - 100011 (lw) or 101011 (sw): MEMADR.
  - 000000 (R-type): RTYPEEX.
  - 000100 (beq): BEQEX.
  - 001000 (addi): ADDIEX.
  - 000010 (j): JEX.
  - anything else: FETCH, with `illegal_op`=1.
- MEMADR: `alusrca`, `alusrcb`=10, aluop=00. Next state is MEMRD if lw, MEMWR if sw.
- MEMRD: `iord`. Next state is MEMWB.
- MEMWB: `mem2reg`, `regwrite`, `instr_done`. Next state is FETCH.
- MEMWR: `iord`, `memwrite`, `instr_done`. Next state is FETCH.
- RTYPEEX: `alusrca`, aluop=10. Next state is ALUWB.
- ALUWB: `regdst`, `regwrite`, `instr_done`. Next state is FETCH.
- BEQEX: `alusrca`, aluop=01, `pcsrc`=01, `branch`, `instr_done`. Next state is FETCH.
- ADDIEX: `alusrca`, `alusrcb`=10, aluop=00. Next state is ADDIWB.
- ADDIWB: `regwrite`, `instr_done`. Next state is FETCH.
- JEX: `pcsrc`=10, `pcwrite`, `instr_done`. Next state is FETCH.
- ALU decode: aluop 00 gives 010 (add); aluop 01 gives 110 (sub).
- aluop 10 decodes `funct`:
  - 100000 (add): 010.
  - 100010 (sub): 110.
  - 100100 (and): 000.
  - 100101 (or): 001.
  - 101010 (slt): 111.
  - any other funct: 010, no flag raised.
- `op` is sampled only in DECODE and MEMADR. It must be stable from FETCH+1 until FETCH is re-entered.

## Timing
- Reset:
  - RST high at a rising edge puts the state in FETCH.
  - While RST is high, `pcen`, `memwrite`, `irwrite`, `regwrite`, `illegal_op` and `instr_done` are forced to 0.
  - All select outputs read 0 except `alusrcb`=01 and `alu_control`=010 (FETCH decode).
- The first fetch happens in the cycle after RST deasserts.
- RST asserted mid-instruction aborts it: no write enable asserts from that edge on, and the next state is FETCH.
- Cycles per instruction, counting FETCH as cycle 1:
  - lw: 5
  - sw, R-type, addi: 4
  - beq, j: 3
  - illegal opcode: 2
- `instr_done` is high exactly once per completed instruction, in its last cycle. It is never high for an illegal opcode.
- `pcen` in BEQEX follows `zero` in the same cycle (combinational).

## Structure
- Package `mips_pkg` holds:
  - the opcode constants (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J);
  - the funct constants;
  - the ALU codes;
  - the aluop typedef (2 bits);
  - state enum `ctrl_state_t`, 4 bits, with FETCH=0 through JEX=11.
- One sub-module, `alu_decoder`: combinational aluop + `funct` → `alu_control`.

## Test plan
- Reset: RST high 2 cycles with `op`=000000 → `pcen`=`irwrite`=`regwrite`=`memwrite`=0 throughout. Cycle after release: state FETCH, `irwrite`=1, `pcen`=1.
- lw: `op`=100011 → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite`=1, `mem2reg`=1 in cycle 5 only. `instr_done` in cycle 5.
- sw: `op`=101011 → `memwrite`=1, `iord`=1 in cycle 4 only. `regwrite` is never 1.
- R-type: `op`=000000 with `funct`=100010 → `alu_control`=110 in RTYPEEX, then `regdst`=1, `regwrite`=1 in cycle 4. Repeat with `funct`=101010 → `alu_control`=111.
- beq: `op`=000100 with `zero`=1 → `pcen`=1, `pcsrc`=01 in cycle 3. Repeat with `zero`=0 → `pcen`=0 in cycle 3.
- Illegal opcode and abort: `op`=111111 → `illegal_op` pulse in cycle 2, FETCH in cycle 3. Then lw with RST raised in MEMRD → `regwrite` never asserts, FETCH in the cycle after RST drops.
